// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the round-robin pick used by the adder arbiter.
package fp16_pkg;

    localparam logic [15:0] FP16_QNAN = 16'h7FFF;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    // Returns {found, idx}; search starts at last+1 and wraps modulo n (n <= 8).
    function automatic logic [3:0] rr_pick(
        input logic [7:0] elig,
        input logic [2:0] last,
        input int         n
    );
        logic [3:0] r;
        int         idx;
        r = 4'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !r[3] && elig[idx[2:0]]) begin
                r = {1'b1, idx[2:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fp16_adder.sv
// FP16 adder, round-to-nearest-even, one registered stage.
module fp16_adder
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic [15:0] res_d;
    logic        a_nan, b_nan, a_inf, b_inf, swap, stk, rnd;
    logic [15:0] l, s;
    logic [5:0]  el, es, d, e, exp_f;
    logic [13:0] ml, ms, shs, lost, n;
    logic [14:0] sm;
    logic [15:0] pk;

    always_comb begin
        a_nan = (&a[14:10]) && (|a[9:0]);
        b_nan = (&b[14:10]) && (|b[9:0]);
        a_inf = (&a[14:10]) && !(|a[9:0]);
        b_inf = (&b[14:10]) && !(|b[9:0]);
        swap  = b[14:0] > a[14:0];
        l     = swap ? b : a;
        s     = swap ? a : b;
        el    = (l[14:10] == 5'd0) ? 6'd1 : {1'b0, l[14:10]};
        es    = (s[14:10] == 5'd0) ? 6'd1 : {1'b0, s[14:10]};
        ml    = {|l[14:10], l[9:0], 3'b000};
        ms    = {|s[14:10], s[9:0], 3'b000};
        d     = el - es;
        lost  = 14'd0;
        if (d >= 6'd14) begin
            shs = 14'd0;
            stk = |ms;
        end else begin
            shs  = ms >> d;
            lost = ms << (6'd14 - d);
            stk  = |lost;
        end
        shs[0] = shs[0] | stk;
        if (l[15] == s[15]) sm = {1'b0, ml} + {1'b0, shs};
        else                sm = {1'b0, ml} - {1'b0, shs};
        e = el;
        n = sm[13:0];
        if (sm[14]) begin
            n = sm[14:1] | {13'd0, sm[0]};
            e = el + 6'd1;
        end else begin
            // Normalise left, but never below the subnormal exponent.
            for (int i = 0; i < 14; i++) begin
                if (!n[13] && e > 6'd1) begin
                    n = n << 1;
                    e = e - 6'd1;
                end
            end
        end
        exp_f = n[13] ? e : 6'd0;
        rnd   = n[2] & (n[1] | n[0] | n[3]);
        pk    = {exp_f, n[12:3]} + {15'd0, rnd};
        if (a_nan || b_nan)                       res_d = FP16_QNAN;
        else if (a_inf && b_inf && a[15] != b[15]) res_d = FP16_QNAN;
        else if (a_inf)                           res_d = a;
        else if (b_inf)                           res_d = b;
        else if (sm == 15'd0)
            res_d = (l[15] == s[15]) ? {l[15], 15'd0} : FP16_ZERO;
        else if (pk[15:10] >= 6'd31)
            res_d = l[15] ? FP16_NINF : FP16_PINF;
        else
            res_d = {l[15], pk[14:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum <= FP16_ZERO;
        else     sum <= res_d;
    end

endmodule

// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one fp16_adder among N_REQ requesters.
// Define FP16_ARB_STATS_EN to add per-requester saturating grant counters.
module fp16_add_arbiter
    import fp16_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [16*N_REQ-1:0]   rsp_data,
`ifdef FP16_ARB_STATS_EN
    output logic [16*N_REQ-1:0]   gnt_cnt,
`endif
    output logic                  busy
);

    logic [IDX_W-1:0]    last_q, last_d, inflight_id_q, inflight_id_d, gnt_id;
    logic                inflight_vld_q, inflight_vld_d, gnt_vld;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d, free, elig;
    logic [16*N_REQ-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]          pick;
    logic [15:0]         add_a, add_b, add_sum;

    fp16_adder u_add (
        .clk (clk),
        .rst (~rst_n),
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    always_comb begin
        free = ~rsp_valid_q;
        if (inflight_vld_q) free[inflight_id_q] = 1'b0;
        elig    = req_valid & free;
        pick    = rr_pick(8'(elig), 3'(last_q), N_REQ);
        gnt_vld = pick[3] & rst_n;
        gnt_id  = IDX_W'(pick[2:0]);
        req_ready = '0;
        add_a     = FP16_ZERO;
        add_b     = FP16_ZERO;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
            add_a = req_a[16*gnt_id +: 16];
            add_b = req_b[16*gnt_id +: 16];
        end
        // A grant always handshakes: ready is only raised for a valid requester.
        inflight_vld_d = gnt_vld;
        inflight_id_d  = gnt_vld ? gnt_id : inflight_id_q;
        last_d         = gnt_vld ? gnt_id : last_q;
        rsp_valid_d    = rsp_valid_q & ~rsp_ready;
        rsp_data_d     = rsp_data_q;
        if (inflight_vld_q) begin
            rsp_valid_d[inflight_id_q]          = 1'b1;
            rsp_data_d[16*inflight_id_q +: 16]  = add_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q         <= IDX_W'(N_REQ - 1);
            inflight_vld_q <= 1'b0;
            inflight_id_q  <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
        end else begin
            last_q         <= last_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_id_q  <= inflight_id_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = inflight_vld_q | (|rsp_valid_q);

`ifdef FP16_ARB_STATS_EN
    logic [16*N_REQ-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_vld && gnt_id == IDX_W'(i) && cnt_q[16*i +: 16] != 16'hFFFF)
                cnt_d[16*i +: 16] = cnt_q[16*i +: 16] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter with hand-computed FP16 sums.
module tb_fp16_add_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [16*N-1:0] req_a, req_b, rsp_data;
    logic          busy;
`ifdef FP16_ARB_STATS_EN
    logic [16*N-1:0] gnt_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fp16_add_arbiter #(.N_REQ(N), .IDX_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef FP16_ARB_STATS_EN
        .gnt_cnt   (gnt_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    function automatic logic [15:0] rd(input int i);
        return rsp_data[16*i +: 16];
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    logic [15:0] exp35 [4];

    initial begin
        req_a = '0;
        req_b = '0;
        rst_n = 1'b0;
        rsp_ready = '0;
        req_valid = 4'b1111;
        set_op(0, 16'h3C00, 16'h3C00);
        mid();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rspv", 32'(rsp_valid), 32'h0);
        chk("rst_data", rsp_data[31:0], 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single request: 1.0 + 1.0 = 2.0
        do_reset();
        req_valid = 4'b0001;
        mid();
        chk("single_ready_c0", 32'(req_ready), 32'h1);
        nxt();
        req_valid = 4'b0000;
        mid();
        chk("single_rspv_c1", 32'(rsp_valid), 32'h0);
        chk("single_busy_c1", 32'(busy), 32'h1);
        nxt();
        mid();
        chk("single_rspv_c2", 32'(rsp_valid), 32'h1);
        chk("single_data_c2", 32'(rd(0)), 32'h4000);
        nxt();
        rsp_ready = 4'b0001;
        nxt();
        rsp_ready = 4'b0000;
        mid();
        chk("single_pop_rspv", 32'(rsp_valid), 32'h0);
        chk("single_pop_busy", 32'(busy), 32'h0);

        // Four requesters at once: round-robin 0,1,2,3
        do_reset();
        set_op(0, 16'h3C00, 16'h3C00);
        set_op(1, 16'h3C00, 16'h4000);
        set_op(2, 16'h3C00, 16'h0000);
        set_op(3, 16'h3C00, 16'hBC00);
        exp35[0] = 16'h4000;
        exp35[1] = 16'h4200;
        exp35[2] = 16'h3C00;
        exp35[3] = 16'h0000;
        rsp_ready = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            req_valid = 4'(4'b1111 << c);
            mid();
            chk($sformatf("rr_ready_c%0d", c), 32'(req_ready),
                c < 4 ? 32'(1 << c) : 32'h0);
            chk($sformatf("rr_rspv_c%0d", c), 32'(rsp_valid),
                c >= 2 ? 32'(1 << (c - 2)) : 32'h0);
            if (c >= 2)
                chk($sformatf("rr_data_c%0d", c), 32'(rd(c - 2)),
                    32'(exp35[c - 2]));
            nxt();
        end
        req_valid = '0;

        // Backpressure on requester 1
        do_reset();
        set_op(1, 16'h3C00, 16'hBC00);
        req_valid = 4'b0010;
        mid();
        chk("bp_ready_c0", 32'(req_ready), 32'h2);
        nxt();
        set_op(1, 16'h4000, 16'h4000);
        mid();
        chk("bp_ready_c1", 32'(req_ready), 32'h0);
        nxt();
        mid();
        chk("bp_rspv_c2", 32'(rsp_valid), 32'h2);
        chk("bp_data_c2", 32'(rd(1)), 32'h0000);
        chk("bp_ready_c2", 32'(req_ready), 32'h0);
        nxt();
        mid();
        chk("bp_hold_c3", 32'(rsp_valid), 32'h2);
        chk("bp_ready_c3", 32'(req_ready), 32'h0);
        nxt();
        rsp_ready = 4'b0010;
        mid();
        chk("bp_ready_pop", 32'(req_ready), 32'h0);
        nxt();
        rsp_ready = 4'b0000;
        mid();
        chk("bp_rspv_c5", 32'(rsp_valid), 32'h0);
        chk("bp_ready_c5", 32'(req_ready), 32'h2);
        nxt();
        req_valid = '0;
        nxt();
        mid();
        chk("bp_data2", 32'(rd(1)), 32'h4400);

        // Specials: Inf - Inf and overflow
        do_reset();
        set_op(2, 16'h7C00, 16'hFC00);
        set_op(3, 16'h7BFF, 16'h7BFF);
        req_valid = 4'b1100;
        mid();
        chk("sp_ready_c0", 32'(req_ready), 32'h4);
        nxt();
        req_valid = 4'b1000;
        mid();
        chk("sp_ready_c1", 32'(req_ready), 32'h8);
        nxt();
        req_valid = '0;
        mid();
        chk("sp_rspv_c2", 32'(rsp_valid), 32'h4);
        chk("sp_nan", 32'(rd(2)), 32'h7FFF);
        nxt();
        mid();
        chk("sp_rspv_c3", 32'(rsp_valid), 32'hC);
        chk("sp_ovf", 32'(rd(3)), 32'h7C00);

        // Reset while an operation is in flight
        do_reset();
        set_op(0, 16'h3C00, 16'h3C00);
        req_valid = 4'b0001;
        mid();
        chk("mr_ready_c0", 32'(req_ready), 32'h1);
        nxt();
        req_valid = '0;
        rst_n = 1'b0;
        mid();
        chk("mr_busy_rst", 32'(busy), 32'h0);
        nxt();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("mr_rspv_%0d", c), 32'(rsp_valid), 32'h0);
            nxt();
        end
        req_valid = 4'b1111;
        mid();
        chk("mr_first_gnt", 32'(req_ready), 32'h1);
        nxt();
        req_valid = '0;

`ifdef FP16_ARB_STATS_EN
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 4'b0001;
        for (int c = 0; c < 15; c++) nxt();
        req_valid = '0;
        mid();
        chk("st_cnt0", 32'(gnt_cnt[15:0]), 32'd5);
        chk("st_cnt_others", gnt_cnt[63:32], 32'h0);
        chk("st_cnt1", 32'(gnt_cnt[31:16]), 32'h0);
        force dut.cnt_q = 64'h0000_0000_0000_FFFF;
        nxt();
        release dut.cnt_q;
        req_valid = 4'b0001;
        mid();
        chk("st_sat_ready", 32'(req_ready), 32'h1);
        nxt();
        req_valid = '0;
        mid();
        chk("st_sat", 32'(gnt_cnt[15:0]), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
